// File: rtl/idli_uart_tx.sv
// idli_uart_tx: DST_UART transmit path. Collects four 4b slices into a 16b word,
// queues words in a FIFO and sends each as two 8N1 frames, low byte first.
// Optional feature: define IDLI_UART_TX_PARITY_EN to add an even-parity bit per frame.
module idli_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_ctr,
  input  logic       i_wr_en,
  input  logic [3:0] i_slice,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic          wr_act_q, wr_act_d;
  logic [15:0]   stage_q, stage_d;
  logic          push_req, push, pop;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, busy_q, busy_d, tx_q, tx_d;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [15:0]   shreg_q;
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          sel_q, sel_d;
  logic [7:0]    cur_byte;
  logic          bit_end;

  // A word is only started at ctr=0 with room in the FIFO; any gap in i_wr_en abandons it.
  always_comb begin
    wr_act_d = wr_act_q;
    stage_d  = stage_q;
    push_req = 1'b0;
    if (!i_wr_en) begin
      wr_act_d = 1'b0;
    end else if (i_ctr == 2'd0) begin
      wr_act_d = !full_q;
      if (!full_q) stage_d[3:0] = i_slice;
    end else if (wr_act_q) begin
      case (i_ctr)
        2'd1:    stage_d[7:4]  = i_slice;
        2'd2:    stage_d[11:8] = i_slice;
        default: begin
          stage_d[15:12] = i_slice;
          push_req       = 1'b1;
          wr_act_d       = 1'b0;
        end
      endcase
    end
  end

  assign push = push_req && !full_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_CNT);
    busy_d = (count_q != '0) || (state_q != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= stage_d;
    if (pop)  shreg_q       <= mem[rd_ptr_q];
  end

  // Line driver: o_tx is registered from the current state, so it trails the FSM by one cycle.
  assign cur_byte = sel_q ? shreg_q[15:8] : shreg_q[7:0];
  assign bit_end  = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    tx_d    = 1'b1;
    if (state_q != S_IDLE) cnt_d = bit_end ? BAUD_RELOAD : cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sel_d   = 1'b0;
          cnt_d   = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef IDLI_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        tx_d = ^cur_byte;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (sel_q) begin
            state_d = S_IDLE;
          end else begin
            sel_d   = 1'b1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_act_q <= 1'b0;
      stage_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      wr_act_q <= wr_act_d;
      stage_q  <= stage_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sel_q    <= sel_d;
    end
  end

  assign o_full = full_q;
  assign o_busy = busy_q;
  assign o_tx   = tx_q;

endmodule

// File: tb/tb_idli_uart_tx.sv
// Bench for idli_uart_tx: a line-level UART decoder checks the bytes on o_tx
// against a byte-queue model built from the words the bench writes.
module tb_idli_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef IDLI_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYC = 2 * FRAME_BITS * C;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] ctr   = 2'd0;
  logic       wr_en = 1'b0;
  logic [3:0] slice = 4'd0;
  logic       full, busy, tx;

  idli_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ctr  (ctr),
    .i_wr_en(wr_en),
    .i_slice(slice),
    .o_full (full),
    .o_busy (busy),
    .o_tx   (tx)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART line decoder: samples mid-bit on the falling clock edge.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
`ifdef IDLI_UART_TX_PARITY_EN
  logic       par_q[$];
  int         par_err = 0;
`endif
  int         stop_err  = 0;
  int         start_err = 0;
  logic       m_act = 1'b0;
  int         m_cnt = 0;
  int         m_k   = 0;
  logic [7:0] m_byte = 8'd0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act = 1'b1;
        m_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if ((m_cnt % C) == C / 2) begin
        m_k = m_cnt / C;
        if (m_k == 0) begin
          if (tx !== 1'b0) start_err++;
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = tx;
`ifdef IDLI_UART_TX_PARITY_EN
        end else if (m_k == 9) begin
          par_q.push_back(tx);
          if (tx !== ^m_byte) par_err++;
`endif
        end else begin
          if (tx !== 1'b1) stop_err++;
          rx_q.push_back(m_byte);
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // abort_at = 0..3 drops i_wr_en on that slice; 4 writes the whole word.
  task automatic write_word(input logic [15:0] w, input int abort_at);
    for (int n = 0; n < 4; n++) begin
      ctr   = n[1:0];
      wr_en = (n != abort_at);
      slice = w[4*n +: 4];
      tick(1);
    end
    wr_en = 1'b0;
    ctr   = 2'd0;
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i;
    i = 0;
    tick(2);
    while (busy !== 1'b0 && i < max) begin
      tick(1);
      i++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 32'hDEAD, exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  // Single word with cycle-level timing of the line and busy flag.
  task automatic timed_word(input string tag, input logic [15:0] w);
    int k;
    write_word(w, 4);
    expect_word(w);
    chk({tag, "_busy_at_push"}, busy, 1'b0);
    tick(1);
    chk({tag, "_busy_push1"}, busy, 1'b1);
    chk({tag, "_tx_push1"}, tx, 1'b1);
    tick(1);
    chk({tag, "_tx_push2"}, tx, 1'b0);
    k = 0;
    while (busy === 1'b1 && k < 4 * WORD_CYC) begin
      tick(1);
      k++;
    end
    chk({tag, "_word_cycles"}, k, WORD_CYC);
    chk({tag, "_tx_after"}, tx, 1'b1);
  endtask

  initial begin
    int bad_tx, bad_busy, bad_full, g;
    logic [15:0] w;

    tick(2);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    rst = 1'b0;

    bad_tx = 0; bad_busy = 0; bad_full = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (full !== 1'b0) bad_full++;
    end
    chk("idle_tx_bad", bad_tx, 0);
    chk("idle_busy_bad", bad_busy, 0);
    chk("idle_full_bad", bad_full, 0);

    timed_word("a55a", 16'hA55A);
    tick(C);
    check_rx("a55a");

    for (int i = 1; i <= 5; i++) begin
      write_word(16'(i), 4);
      expect_word(16'(i));
      if (i == 4) chk("full_after4", full, 1'b0);
    end
    chk("full_after5", full, 1'b1);
    write_word(16'h0006, 4);
    chk("full_after_drop", full, 1'b1);
    wait_idle("b2b", 8 * WORD_CYC);
    chk("b2b_full_end", full, 1'b0);
    chk("b2b_nstarts", start_q.size(), 10);
    if (start_q.size() >= 3) begin
      chk("b2b_frame_gap", start_q[1] - start_q[0], FRAME_BITS * C);
      chk("b2b_word_gap", start_q[2] - start_q[0], WORD_CYC + 1);
    end
    check_rx("b2b");

    write_word(16'h9999, 2);
    write_word(16'h1234, 4);
    expect_word(16'h1234);
    wait_idle("abort", 4 * WORD_CYC);
    check_rx("abort");

    write_word(16'hC3C3, 4);
    tick(2 + 3 * C);
    chk("tx_before_rst", tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_full", full, 1'b0);
    tick(2);
    rst = 1'b0;
    chk("midrst_partial", rx_q.size(), 0);
    rx_q.delete();
    start_q.delete();
    write_word(16'h00FF, 4);
    expect_word(16'h00FF);
    wait_idle("post_rst", 4 * WORD_CYC);
    check_rx("post_rst");

`ifdef IDLI_UART_TX_PARITY_EN
    par_q.delete();
    timed_word("par0307", 16'h0307);
    tick(C);
    chk("par_n", par_q.size(), 2);
    if (par_q.size() == 2) begin
      chk("par_lo", par_q[0], 1'b1);
      chk("par_hi", par_q[1], 1'b0);
    end
    check_rx("par0307");
`endif

    for (int t = 0; t < 24; t++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        write_word(w, $urandom_range(0, 3));
      end else begin
        g = 0;
        while (full === 1'b1 && g < 2 * WORD_CYC) begin
          tick(1);
          g++;
        end
        chk($sformatf("rand_stall%0d", t), full, 1'b0);
        write_word(w, 4);
        expect_word(w);
      end
      tick($urandom_range(0, 60));
    end
    wait_idle("rand", (DEPTH + 2) * (WORD_CYC + 1));
    check_rx("rand");

    chk("start_err", start_err, 0);
    chk("stop_err", stop_err, 0);
`ifdef IDLI_UART_TX_PARITY_EN
    chk("par_err", par_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idli_uart_tx.md
# idli_uart_tx

UART transmit path for the core's `DST_UART` destination: the transmit-side counterpart of the `SRC_UART` receive path. It accepts 16b words from the execute pipe as four 4b slices over one instruction's four cycles. Accepted words are buffered in a small FIFO. Each word goes out on a single TX pin as two 8N1 frames, low byte first. It sits beside the register file/ALU output mux and is written whenever an operation's destination is the UART.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: buffered 16b words; power of two, >= 2.
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_ctr`  in  2  shared instruction cycle counter (`ctr_t`); 0..3 selects the slice.
- `i_wr_en`  in  1  write strobe; must be high on all four cycles of a word.
- `i_slice`  in  4  data slice (`slice_t`); `i_ctr`=n carries word bits [4n+3:4n].
- `o_full`  out  1  registered; high when the FIFO holds `FIFO_DEPTH` words.
- `o_busy`  out  1  registered; high while the FIFO is non-empty or a frame is in flight.
- `o_tx`  out  1  registered UART TX line; idle high.

## Operation
- Assembly: slices are collected into a 16b staging register.
  - A write starts with `i_wr_en`=1 at `i_ctr`=0 and `o_full`=0.
  - Slices for `i_ctr`=1,2,3 need `i_wr_en`=1 on each cycle.
  - The word is pushed on the `i_ctr`=3 edge.
- Discards:
  - If `i_wr_en` drops mid-word, the partial word is discarded and nothing is pushed.
  - `i_wr_en` at `i_ctr`!=0 with no write in progress is ignored.
- Full: a write started while `o_full`=1 is dropped whole. There is no state change and no error flag. The core is responsible for stalling on `o_full`.
- Push while full: rejected even if a pop occurs on the same edge.
- Push/pop same cycle, not full: both occur and the count is unchanged.
- FIFO: circular buffer with rd/wr pointers of log2(`FIFO_DEPTH`) bits that wrap at depth. A count of log2+1 bits drives `o_full`.
- TX FSM states: IDLE, START, DATA, STOP, plus `byte_sel` (0 = low byte, 1 = high byte).
  - IDLE, FIFO non-empty: pop the word into the shift source, `byte_sel`=0, go to START.
  - START: `o_tx`=0 for one bit time, then DATA.
  - DATA: 8 bits LSB first, one bit time each; 3b bit index; then STOP.
  - STOP: `o_tx`=1 for one bit time.
  - End of STOP with `byte_sel`=0: set `byte_sel`=1, go to START.
  - End of STOP with `byte_sel`=1: go to IDLE.
- Baud counter: 16b, counts `CLKS_PER_BIT`-1 down to 0. It reloads on every bit boundary and on IDLE→START.
- `o_busy` = FIFO non-empty OR FSM != IDLE.

## Timing
- Reset values: `o_tx`=1, `o_full`=0, `o_busy`=0, FSM=IDLE, FIFO empty, staging cleared. Async assert; the first push can occur on the first edge after deassert.
- Reset mid-frame: `o_tx` returns high immediately. The FIFO contents and the partial frame are lost.
- Latency: the last slice edge (`i_ctr`=3) pushes. `o_busy` rises one cycle later, and the FSM enters START on that same edge. `o_tx` falls 2 edges after the last slice.
- Bit duration is exactly `CLKS_PER_BIT` cycles.
  - Frame = 10 bit times.
  - Word = 20 bit times, with no gap between the two frames.
  - Back-to-back words: the next START begins one cycle after the final STOP, for the IDLE pop.
- `o_full` updates on the push/pop edge and is visible the following cycle.

## Configuration
- `IDLI_UART_TX_PARITY_EN`: when defined, a PARITY state is inserted between DATA and STOP.
  - It drives even parity, the XOR of the 8 data bits.
  - Frame = 11 bit times; word = 22 bit times.
- Undefined: no parity state; 8N1 framing.

## Test plan
- Reset, then idle 100 cycles with `CLKS_PER_BIT`=4 -> `o_tx`=1, `o_busy`=0, `o_full`=0 throughout.
- Write 0xA55A (slices A,5,5,A for ctr 0..3) with `CLKS_PER_BIT`=4.
  - `o_tx` falls 2 cycles after the ctr=3 edge.
  - Decoded bytes are 0x5A then 0xA5, each with stop=1.
  - 80 cycles in total; `o_busy` falls afterwards.
- Five back-to-back writes 0x0001..0x0005 with `FIFO_DEPTH`=4.
  - `o_full` rises after the fifth push.
  - Decoded stream is 01 00 02 00 03 00 04 00 05 00.
- Sixth write while `o_full`=1 -> dropped; the stream omits it and the count stays 4.
- Write abandoned by dropping `i_wr_en` at ctr=2, then a valid 0x1234 -> only bytes 34 12 are transmitted.
- Assert `i_rst` mid-DATA -> `o_tx`=1 and `o_busy`=0 immediately; a new write of 0x00FF then sends FF 00 cleanly.
- `IDLI_UART_TX_PARITY_EN` defined, write 0x0307 -> parity bits 1 then 0; 22 bit times per word.
